// File: rtl/frida_compmux_pkg.sv
// Shared constants and state type for the comparator-mux scan controller.
package frida_compmux_pkg;
  localparam int N_CH  = 16;
  localparam int SEL_W = 4;
  localparam int SET_W = 8;
  localparam int SMP_W = 8;
  localparam int CNT_W = (SET_W > SMP_W) ? SET_W : SMP_W;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, REPORT} scan_state_t;
endpackage

// File: rtl/compmux_next_ch.sv
// Priority finder: lowest enabled channel strictly above cur_i, or the lowest
// enabled channel overall when lowest_i is set.
module compmux_next_ch
  import frida_compmux_pkg::*;
(
  input  logic [N_CH-1:0]  mask_i,
  input  logic [SEL_W-1:0] cur_i,
  input  logic             lowest_i,
  output logic [SEL_W-1:0] nxt_o,
  output logic             found_o
);

  // Descending walk so the last hit, i.e. the lowest index, wins.
  always_comb begin
    nxt_o   = '0;
    found_o = 1'b0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (mask_i[i] && (lowest_i || (i > int'(cur_i)))) begin
        nxt_o   = SEL_W'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/compmux_scan_ctrl.sv
// Comparator mux select controller: static hold or scan of enabled ADCs,
// counting synchronized comparator ones per channel.
module compmux_scan_ctrl
  import frida_compmux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode_scan,
  input  logic [SEL_W-1:0] static_sel,
  input  logic [N_CH-1:0]  ch_en,
  input  logic [SET_W-1:0] settle_cyc,
  input  logic [SMP_W-1:0] n_samp,
  input  logic             continuous,
  input  logic             start,
  input  logic             abort,
  input  logic             comp_in,
  output logic [SEL_W-1:0] mux_sel,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [SEL_W-1:0] res_ch,
  output logic [SMP_W-1:0] res_ones
);

  scan_state_t      state_q, state_d;
  logic             comp_s1_q, comp_s2_q;
  logic [N_CH-1:0]  en_q, en_d;
  logic [SET_W-1:0] set_q, set_d;
  logic [SMP_W-1:0] smp_q, smp_d;
  logic             cont_q, cont_d;
  logic [SEL_W-1:0] first_q, first_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SMP_W-1:0] ones_q, ones_d;
  logic             done_q, done_d;

  logic [N_CH-1:0]  fnd_mask;
  logic             fnd_lowest;
  logic [SEL_W-1:0] fnd_nxt;
  logic             fnd_found;

  // In IDLE the live mask is searched for the first channel; during a pass the shadow mask.
  assign fnd_mask   = (state_q == IDLE) ? ch_en : en_q;
  assign fnd_lowest = (state_q == IDLE);

  compmux_next_ch u_next_ch (
    .mask_i   (fnd_mask),
    .cur_i    (sel_q),
    .lowest_i (fnd_lowest),
    .nxt_o    (fnd_nxt),
    .found_o  (fnd_found)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      comp_s1_q <= 1'b0;
      comp_s2_q <= 1'b0;
      en_q      <= '0;
      set_q     <= '0;
      smp_q     <= '0;
      cont_q    <= 1'b0;
      first_q   <= '0;
      sel_q     <= '0;
      cnt_q     <= '0;
      ones_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      comp_s1_q <= comp_in;
      comp_s2_q <= comp_s1_q;
      en_q      <= en_d;
      set_q     <= set_d;
      smp_q     <= smp_d;
      cont_q    <= cont_d;
      first_q   <= first_d;
      sel_q     <= sel_d;
      cnt_q     <= cnt_d;
      ones_q    <= ones_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    set_d   = set_q;
    smp_d   = smp_q;
    cont_d  = cont_q;
    first_d = first_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!mode_scan) begin
            sel_d = static_sel;
          end else if (start) begin
            en_d   = ch_en;
            set_d  = settle_cyc;
            smp_d  = (n_samp == '0) ? SMP_W'(1) : n_samp;
            cont_d = continuous;
            if (fnd_found) begin
              first_d = fnd_nxt;
              sel_d   = fnd_nxt;
              cnt_d   = CNT_W'(settle_cyc);
              ones_d  = '0;
              state_d = SETTLE;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        // Count reaching 1 (or a zero load) ends the phase, so a zero settle still costs one cycle.
        SETTLE: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = CNT_W'(smp_q);
            state_d = SAMPLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        SAMPLE: begin
          ones_d = ones_q + SMP_W'(comp_s2_q);
          if (cnt_q == CNT_W'(1)) state_d = REPORT;
          else                    cnt_d   = cnt_q - CNT_W'(1);
        end
        default: begin
          if (res_ready) begin
            if (fnd_found) begin
              sel_d   = fnd_nxt;
              cnt_d   = CNT_W'(set_q);
              ones_d  = '0;
              state_d = SETTLE;
            end else begin
              done_d = 1'b1;
              // A cleared mode_scan stops a continuous scan at the pass boundary.
              if (cont_q && mode_scan) begin
                sel_d   = first_q;
                cnt_d   = CNT_W'(set_q);
                ones_d  = '0;
                state_d = SETTLE;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    mux_sel   = sel_q;
    busy      = (state_q != IDLE);
    done      = done_q;
    res_valid = (state_q == REPORT);
    res_ch    = sel_q;
    res_ones  = ones_q;
  end

endmodule
